soc_reset_sequencer: RTL and testbench

- Generates the SoC core reset from PLL lock status and an external reset request. Replaces the free-running counter-tap reset generator.
- Sits between the PLL and the picorv32 Wishbone SoC, in the PLL output clock domain.
- Holds the SoC in reset until lock has been stable for a set time, then releases it after a fixed hold.
- Re-enters reset on lock loss or on a debounced external request, and records the cause.

---
 rtl/soc_reset_pkg.sv | 20 ++
 rtl/soc_reset_sync_debounce.sv | 51 +++++
 rtl/soc_reset_sequencer.sv | 123 ++++++++++++
 tb/tb_soc_reset_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_reset_pkg.sv
// Shared constants for the SoC reset sequencer: FSM state codes, reset cause codes, widths.
// Latency: none (definitions only). Backpressure: n/a.
package soc_reset_pkg;

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] STABLE    = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_EXT  = 2'b10;

    localparam int RST_COUNT_W = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/soc_reset_sync_debounce.sv
// Synchroniser chain plus optional debounce; DEBOUNCE_CYCLES=0 passes the synchronised level straight out.
// Latency: SYNC_STAGES cycles, plus DEBOUNCE_CYCLES-1 to the single qualify pulse. Backpressure: none.
module sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic qualified
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   sync_lvl;

    always_ff @(posedge clock) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_lvl = chain[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign qualified = sync_lvl;
        end else begin : g_debounce
            localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
            localparam logic [DB_W-1:0] DB_FIRE = DB_W'(DEBOUNCE_CYCLES - 1);

            logic [DB_W-1:0] db_cnt;

            // Saturating at DB_MAX means a held input fires exactly once.
            always_ff @(posedge clock) begin
                if (reset) begin
                    db_cnt <= '0;
                end else if (!sync_lvl) begin
                    db_cnt <= '0;
                end else if (db_cnt != DB_MAX) begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end

            assign qualified = sync_lvl && (db_cnt == DB_FIRE);
        end
    endgenerate

endmodule

// File: rtl/soc_reset_sequencer.sv
// SoC reset generator: qualifies PLL lock, holds reset, re-enters reset on lock loss or debounced request.
// Latency: lock rise to release SYNC_STAGES+1+LOCK_STABLE_CYCLES+HOLD_CYCLES; lock loss SYNC_STAGES+1. Backpressure: none.
module soc_reset_sequencer
    import soc_reset_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES        = 256,
    parameter int DEBOUNCE_CYCLES    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       ext_rst_req,
    output logic       sys_reset,
    output logic       sys_ready,
    output logic [1:0] rst_cause,
    output logic [7:0] rst_count
);

    localparam int CNT_W = $clog2(max2(LOCK_STABLE_CYCLES, HOLD_CYCLES) + 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [RST_COUNT_W-1:0] COUNT_MAX = '1;

    logic             lk_s;
    logic             ext_ok;
    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       cause_nxt;
    logic             bump;
    logic [7:0]       count_nxt;

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (0)
    ) u_lock_sync (
        .clock     (clock),
        .reset     (reset),
        .async_in  (pll_locked),
        .qualified (lk_s)
    );

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_req_debounce (
        .clock     (clock),
        .reset     (reset),
        .async_in  (ext_rst_req),
        .qualified (ext_ok)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cause_nxt = rst_cause;
        bump      = 1'b0;
        case (state)
            WAIT_LOCK: begin
                cnt_nxt = '0;
                if (lk_s) state_nxt = STABLE;
            end
            STABLE: begin
                if (!lk_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (!lk_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                cnt_nxt = '0;
                // Lock loss outranks a coincident button press.
                if (!lk_s) begin
                    state_nxt = WAIT_LOCK;
                    cause_nxt = CAUSE_LOCK;
                    bump      = 1'b1;
                end else if (ext_ok) begin
                    state_nxt = HOLD;
                    cause_nxt = CAUSE_EXT;
                    bump      = 1'b1;
                end
            end
        endcase
    end

    assign count_nxt = (bump && (rst_count != COUNT_MAX)) ? rst_count + 1'b1 : rst_count;

    // Outputs are registered from the next state so they change on the transition edge itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            sys_reset <= 1'b1;
            sys_ready <= 1'b0;
            rst_cause <= CAUSE_POR;
            rst_count <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sys_reset <= (state_nxt != RUN);
            sys_ready <= (state_nxt == RUN);
            rst_cause <= cause_nxt;
            rst_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Self-checking bench for soc_reset_sequencer against a remaining-qualification-cycles model.
// Latency/backpressure: n/a.
module tb_soc_reset_sequencer;

    localparam int SS  = 2;
    localparam int LS  = 8;
    localparam int HC  = 4;
    localparam int DC  = 3;
    localparam int REL = SS + 1 + LS + HC;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       ext_rst_req = 1'b0;
    logic       sys_reset;
    logic       sys_ready;
    logic [1:0] rst_cause;
    logic [7:0] rst_count;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    soc_reset_sequencer #(
        .SYNC_STAGES        (SS),
        .LOCK_STABLE_CYCLES (LS),
        .HOLD_CYCLES        (HC),
        .DEBOUNCE_CYCLES    (DC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .ext_rst_req (ext_rst_req),
        .sys_reset   (sys_reset),
        .sys_ready   (sys_ready),
        .rst_cause   (rst_cause),
        .rst_count   (rst_count)
    );

    // Reference model: inputs are seen SS edges late; m_rem is the number of
    // lock-qualified edges still needed before the SoC is released.
    logic [SS-1:0] m_lk_p, m_rq_p;
    int            m_run, m_rem, m_count;
    logic          m_running;
    logic [1:0]    m_cause;

    task automatic model_step();
        logic lk, rq, ok;
        if (reset) begin
            m_lk_p = '0; m_rq_p = '0; m_run = 0; m_running = 1'b0;
            m_rem = REL - SS; m_cause = 2'b00; m_count = 0;
        end else begin
            lk = m_lk_p[SS-1];
            rq = m_rq_p[SS-1];
            m_run = rq ? m_run + 1 : 0;
            ok = (m_run == DC);
            if (!lk) begin
                if (m_running) begin
                    m_cause = 2'b01;
                    m_count = (m_count < 255) ? m_count + 1 : 255;
                end
                m_running = 1'b0;
                m_rem = REL - SS;
            end else if (m_running) begin
                if (ok) begin
                    m_cause = 2'b10;
                    m_count = (m_count < 255) ? m_count + 1 : 255;
                    m_running = 1'b0;
                    m_rem = HC;
                end
            end else begin
                m_rem = m_rem - 1;
                if (m_rem == 0) m_running = 1'b1;
            end
            m_lk_p = {m_lk_p[SS-2:0], pll_locked};
            m_rq_p = {m_rq_p[SS-2:0], ext_rst_req};
        end
    endtask

    function automatic logic [11:0] m_vec();
        logic [7:0] c;
        c = m_count[7:0];
        return {~m_running, m_running, m_cause, c};
    endfunction

    function automatic logic [11:0] d_vec();
        return {sys_reset, sys_ready, rst_cause, rst_count};
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pll_locked = 1'b0; ext_rst_req = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (d_vec() !== 12'h800) begin
            n_miss++; $display("FAIL reset_values got=%h want=%h", d_vec(), 12'h800);
        end
        n_vec++;
        if (d_vec() !== m_vec()) begin
            n_miss++; $display("FAIL reset_model got=%h want=%h", d_vec(), m_vec());
        end
        reset = 1'b0;
    endtask

    task automatic test_power_up();
        int n = 0;
        pll_locked = 1'b1;
        while (sys_reset && n < 40) begin
            tick(); n++;
            n_vec++;
            if (d_vec() !== m_vec()) begin
                n_miss++; $display("FAIL power_up_cycle%0d got=%h want=%h", n, d_vec(), m_vec());
            end
        end
        n_vec++;
        if (n !== REL) begin
            n_miss++; $display("FAIL power_up_latency got=%0d want=%0d", n, REL);
        end
        n_vec++;
        if ({sys_ready, rst_cause, rst_count} !== {1'b1, 2'b00, 8'd0}) begin
            n_miss++; $display("FAIL power_up_status got=%b/%b/%0d want=1/00/0", sys_ready, rst_cause, rst_count);
        end
    endtask

    task automatic test_lock_glitch();
        int n = 0;
        reset = 1'b1; pll_locked = 1'b0;
        repeat (2) tick();
        reset = 1'b0; pll_locked = 1'b1;
        repeat (SS + 1 + 5) begin
            tick();
            n_vec++;
            if (d_vec() !== m_vec()) begin
                n_miss++; $display("FAIL glitch_pre got=%h want=%h", d_vec(), m_vec());
            end
        end
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        while (sys_reset && n < 40) begin
            tick(); n++;
            n_vec++;
            if (d_vec() !== m_vec()) begin
                n_miss++; $display("FAIL glitch_cycle%0d got=%h want=%h", n, d_vec(), m_vec());
            end
        end
        n_vec++;
        if (n !== REL) begin
            n_miss++; $display("FAIL glitch_requalify got=%0d want=%0d", n, REL);
        end
        n_vec++;
        if (rst_count !== 8'd0) begin
            n_miss++; $display("FAIL glitch_count got=%0d want=0", rst_count);
        end
    endtask

    task automatic test_lock_loss();
        int n = 0;
        pll_locked = 1'b0;
        while (!sys_reset && n < 10) begin
            tick(); n++;
            n_vec++;
            if (d_vec() !== m_vec()) begin
                n_miss++; $display("FAIL loss_cycle%0d got=%h want=%h", n, d_vec(), m_vec());
            end
        end
        n_vec++;
        if (n !== SS + 1) begin
            n_miss++; $display("FAIL loss_latency got=%0d want=%0d", n, SS + 1);
        end
        n_vec++;
        if ({sys_ready, rst_cause, rst_count} !== {1'b0, 2'b01, 8'd1}) begin
            n_miss++; $display("FAIL loss_status got=%b/%b/%0d want=0/01/1", sys_ready, rst_cause, rst_count);
        end
        repeat ($urandom_range(1, 6)) tick();
        pll_locked = 1'b1;
        n = 0;
        while (sys_reset && n < 40) begin
            tick(); n++;
            n_vec++;
            if (d_vec() !== m_vec()) begin
                n_miss++; $display("FAIL relock_cycle%0d got=%h want=%h", n, d_vec(), m_vec());
            end
        end
        n_vec++;
        if (n !== REL) begin
            n_miss++; $display("FAIL relock_latency got=%0d want=%0d", n, REL);
        end
    endtask

    task automatic test_ext_request();
        int hi = 0;
        ext_rst_req = 1'b1;
        repeat (2) tick();
        ext_rst_req = 1'b0;
        repeat (10) begin
            tick();
            n_vec++;
            if (d_vec() !== m_vec()) begin
                n_miss++; $display("FAIL short_pulse got=%h want=%h", d_vec(), m_vec());
            end
        end
        n_vec++;
        if (sys_reset !== 1'b0) begin
            n_miss++; $display("FAIL short_pulse_ignored got=%b want=0", sys_reset);
        end
        ext_rst_req = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (sys_reset) hi++;
            if (i == 9) ext_rst_req = 1'b0;
            n_vec++;
            if (d_vec() !== m_vec()) begin
                n_miss++; $display("FAIL long_press_cycle%0d got=%h want=%h", i, d_vec(), m_vec());
            end
        end
        n_vec++;
        if (hi !== HC) begin
            n_miss++; $display("FAIL long_press_hold got=%0d want=%0d", hi, HC);
        end
        n_vec++;
        if ({sys_ready, rst_cause, rst_count} !== {1'b1, 2'b10, 8'd2}) begin
            n_miss++; $display("FAIL long_press_status got=%b/%b/%0d want=1/10/2", sys_ready, rst_cause, rst_count);
        end
    endtask

    task automatic test_simultaneous();
        int n = 0;
        ext_rst_req = 1'b1;
        repeat (2) tick();
        pll_locked = 1'b0;
        repeat (12) begin
            tick();
            n_vec++;
            if (d_vec() !== m_vec()) begin
                n_miss++; $display("FAIL simul_cycle got=%h want=%h", d_vec(), m_vec());
            end
        end
        n_vec++;
        if ({sys_reset, rst_cause, rst_count} !== {1'b1, 2'b01, 8'd3}) begin
            n_miss++; $display("FAIL simul_cause got=%b/%b/%0d want=1/01/3", sys_reset, rst_cause, rst_count);
        end
        ext_rst_req = 1'b0;
        pll_locked = 1'b1;
        while (sys_reset && n < 40) begin
            tick(); n++;
            n_vec++;
            if (d_vec() !== m_vec()) begin
                n_miss++; $display("FAIL simul_relock got=%h want=%h", d_vec(), m_vec());
            end
        end
        n_vec++;
        if (n !== REL) begin
            n_miss++; $display("FAIL simul_relock_latency got=%0d want=%0d", n, REL);
        end
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 260; r++) begin
            int n = 0;
            ext_rst_req = 1'b1;
            repeat ($urandom_range(5, 8)) tick();
            ext_rst_req = 1'b0;
            while (!sys_ready && n < 30) begin
                tick(); n++;
            end
            repeat ($urandom_range(0, 3)) tick();
            n_vec++;
            if (d_vec() !== m_vec()) begin
                n_miss++; $display("FAIL sat_iter%0d got=%h want=%h", r, d_vec(), m_vec());
            end
        end
        n_vec++;
        if ({rst_cause, rst_count} !== {2'b10, 8'd255}) begin
            n_miss++; $display("FAIL sat_count got=%b/%0d want=10/255", rst_cause, rst_count);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        ext_rst_req = 1'b1;
        repeat (5) tick();
        ext_rst_req = 1'b0;
        tick();
        n_vec++;
        if ({sys_reset, sys_ready} !== 2'b10) begin
            n_miss++; $display("FAIL mid_in_hold got=%b want=10", {sys_reset, sys_ready});
        end
        reset = 1'b1;
        tick();
        n_vec++;
        if (d_vec() !== 12'h800) begin
            n_miss++; $display("FAIL mid_reset_values got=%h want=%h", d_vec(), 12'h800);
        end
        reset = 1'b0;
        while (sys_reset && n < 40) begin
            tick(); n++;
            n_vec++;
            if (d_vec() !== m_vec()) begin
                n_miss++; $display("FAIL mid_release got=%h want=%h", d_vec(), m_vec());
            end
        end
        n_vec++;
        if (n !== REL) begin
            n_miss++; $display("FAIL mid_release_latency got=%0d want=%0d", n, REL);
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_glitch();
        test_lock_loss();
        test_ext_request();
        test_simultaneous();
        test_saturation();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
